// File: rtl/memu_pkg.sv
// Shared memory-unit types: ROB tag width, default issue-queue depth and the
// packed entry held by the load/store issue queue.
package memu_pkg;

  localparam int ROBEN_W   = 5;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic               is_store;
    logic [ROBEN_W-1:0] roben;
    logic [31:0]        addr;
    logic [31:0]        data;
  } mem_op_t;

endpackage

// File: rtl/mem_issue_fifo.sv
// Circular buffer of memory ops; pointers wrap naturally, count has one extra
// bit so that "full" is representable. Flush empties it in one edge.
module mem_issue_fifo
  import memu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  mem_op_t       i_entry,
  input  logic          i_pop,
  input  logic          i_flush,
  output mem_op_t       o_head,
  output logic [AW:0]   o_count
);

  mem_op_t       r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (i_pop && !i_push) r_count <= r_count - 1'b1;
    end
  end

  // Entry storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_tail] <= i_entry;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue toward the data memory: loads issue at the
// head, stores wait for their ROB commit, load results go out on the CDB.
module mem_issue_queue
  import memu_pkg::mem_op_t;
#(
  parameter int DEPTH   = memu_pkg::DEPTH_DEF,
  // Must match the package width, which sizes the stored entry.
  parameter int ROBEN_W = memu_pkg::ROBEN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_is_store,
  input  logic [ROBEN_W-1:0] in_roben,
  input  logic [31:0]        in_addr,
  input  logic [31:0]        in_data,
  input  logic               commit_valid,
  input  logic [ROBEN_W-1:0] commit_roben,
  input  logic               flush,
  output logic               mem_read_en,
  output logic               mem_write_en,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_data,
  output logic [ROBEN_W-1:0] mem_roben,
  input  logic [31:0]        mem_result,
  input  logic [ROBEN_W-1:0] mem_result_roben,
  output logic               cdb_valid,
  output logic [ROBEN_W-1:0] cdb_roben,
  output logic [31:0]        cdb_result,
  output logic               tag_err
);

  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

  mem_op_t            w_in_op;
  mem_op_t            w_head;
  logic [CW-1:0]      w_count;
  logic               w_push;
  logic               w_head_valid;
  logic               w_commit_hit;
  logic               w_issue;
  logic               r_pend;
  logic [ROBEN_W-1:0] r_pend_tag;

  assign in_ready     = (w_count < FULL_COUNT);
  assign w_push       = in_valid && in_ready && !flush;
  assign w_in_op      = '{is_store: in_is_store, roben: in_roben, addr: in_addr, data: in_data};
  assign w_head_valid = (w_count != '0);
  assign w_commit_hit = commit_valid && (commit_roben == w_head.roben);
  assign w_issue      = w_head_valid && !flush && (!w_head.is_store || w_commit_hit);

  mem_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_in_op),
    .i_pop   (w_issue),
    .i_flush (flush),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Strobes last one cycle; address/data/tag hold between issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_roben    <= '0;
    end else begin
      mem_read_en  <= w_issue && !w_head.is_store;
      mem_write_en <= w_issue &&  w_head.is_store;
      if (w_issue) begin
        mem_addr  <= w_head.addr;
        mem_data  <= w_head.data;
        mem_roben <= w_head.roben;
      end
    end
  end

  // A flush on the response edge drops the pending load's broadcast.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend     <= 1'b0;
      r_pend_tag <= '0;
      cdb_valid  <= 1'b0;
      cdb_roben  <= '0;
      cdb_result <= '0;
      tag_err    <= 1'b0;
    end else begin
      r_pend    <= w_issue && !w_head.is_store;
      if (w_issue) r_pend_tag <= w_head.roben;
      cdb_valid <= r_pend && !flush;
      if (r_pend && !flush) begin
        cdb_roben  <= r_pend_tag;
        cdb_result <= mem_result;
        if (mem_result_roben != r_pend_tag) tag_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue with a behavioural data memory that samples
// strobes on the falling edge; unwritten words read as addr*8+2.
module tb_mem_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_store;
  logic [4:0]  in_roben;
  logic [31:0] in_addr, in_data;
  logic        commit_valid;
  logic [4:0]  commit_roben;
  logic        flush;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_addr, mem_data;
  logic [4:0]  mem_roben;
  logic [31:0] mem_result;
  logic [4:0]  mem_result_roben;
  logic        cdb_valid;
  logic [4:0]  cdb_roben;
  logic [31:0] cdb_result;
  logic        tag_err;

  logic        mem_clr;
  logic        force_en;
  logic [4:0]  force_tag;
  logic [31:0] mem [64];
  logic        mem_wr [64];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_issue_queue #(.DEPTH(4), .ROBEN_W(5)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_roben(in_roben), .in_addr(in_addr), .in_data(in_data),
    .commit_valid(commit_valid), .commit_roben(commit_roben), .flush(flush),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_roben(mem_roben),
    .mem_result(mem_result), .mem_result_roben(mem_result_roben),
    .cdb_valid(cdb_valid), .cdb_roben(cdb_roben), .cdb_result(cdb_result),
    .tag_err(tag_err)
  );

  function automatic logic [31:0] init_word(input logic [5:0] a);
    return {26'd0, a} * 32'd8 + 32'd2;
  endfunction

  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem_wr[i] <= 1'b0;
      mem_result       <= '0;
      mem_result_roben <= '0;
    end else begin
      if (mem_write_en) begin
        mem[mem_addr[5:0]]    <= mem_data;
        mem_wr[mem_addr[5:0]] <= 1'b1;
      end
      if (mem_read_en) begin
        mem_result       <= mem_wr[mem_addr[5:0]] ? mem[mem_addr[5:0]] : init_word(mem_addr[5:0]);
        mem_result_roben <= force_en ? force_tag : mem_roben;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic st, input logic [4:0] rb,
                        input logic [31:0] a, input logic [31:0] d);
    in_valid    = v;
    in_is_store = st;
    in_roben    = rb;
    in_addr     = a;
    in_data     = d;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_clr = 1'b1; force_en = 1'b0; force_tag = '0;
    commit_valid = 1'b0; commit_roben = '0; flush = 1'b0;
    set_op(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if ({mem_read_en, mem_write_en, mem_addr, mem_data, mem_roben} !== 71'd0) begin
      n_errors++; $display("FAIL reset_mem: got rd=%b wr=%b a=%0h d=%0h t=%0d want all 0",
                           mem_read_en, mem_write_en, mem_addr, mem_data, mem_roben);
    end
    n_checks++;
    if ({cdb_valid, cdb_roben, cdb_result, tag_err} !== 39'd0) begin
      n_errors++; $display("FAIL reset_cdb: got v=%b t=%0d r=%0h err=%b want all 0",
                           cdb_valid, cdb_roben, cdb_result, tag_err);
    end
    @(posedge clk); #1;
    rst = 1'b1; mem_clr = 1'b0;
    tick();
  endtask

  task automatic test_load();
    set_op(1, 0, 3, 5, 0);
    tick();
    set_op(0, 0, 0, 0, 0);
    n_checks++;
    if (mem_read_en !== 1'b0) begin n_errors++; $display("FAIL load_e0: got rd=%b want 0", mem_read_en); end
    tick();
    n_checks++;
    if ({mem_read_en, mem_write_en, mem_addr, mem_roben, cdb_valid} !== {1'b1, 1'b0, 32'd5, 5'd3, 1'b0}) begin
      n_errors++; $display("FAIL load_e1: got rd=%b wr=%b a=%0d t=%0d cdb=%b want 1 0 5 3 0",
                           mem_read_en, mem_write_en, mem_addr, mem_roben, cdb_valid);
    end
    tick();
    n_checks++;
    if ({mem_read_en, cdb_valid, cdb_roben, cdb_result} !== {1'b0, 1'b1, 5'd3, 32'd42}) begin
      n_errors++; $display("FAIL load_e2: got rd=%b v=%b t=%0d r=%0d want 0 1 3 42",
                           mem_read_en, cdb_valid, cdb_roben, cdb_result);
    end
    tick();
    n_checks++;
    if (cdb_valid !== 1'b0) begin n_errors++; $display("FAIL load_e3: got v=%b want 0", cdb_valid); end
  endtask

  task automatic test_store();
    logic seen;
    seen = 1'b0;
    set_op(1, 1, 7, 10, 99);
    tick();
    set_op(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      commit_valid = (i == 2);
      commit_roben = 5'd6;
      tick();
      seen = seen | mem_write_en | mem_read_en;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_errors++; $display("FAIL store_stall: got strobe=%b want 0", seen); end
    commit_valid = 1'b1; commit_roben = 5'd7;
    tick();
    commit_valid = 1'b0;
    n_checks++;
    if ({mem_write_en, mem_read_en, mem_addr, mem_data, mem_roben} !== {1'b1, 1'b0, 32'd10, 32'd99, 5'd7}) begin
      n_errors++; $display("FAIL store_issue: got wr=%b rd=%b a=%0d d=%0d t=%0d want 1 0 10 99 7",
                           mem_write_en, mem_read_en, mem_addr, mem_data, mem_roben);
    end
    tick();
    n_checks++;
    if ({mem_write_en, cdb_valid} !== 2'b00) begin
      n_errors++; $display("FAIL store_after: got wr=%b cdb=%b want 0 0", mem_write_en, cdb_valid);
    end
    set_op(1, 0, 8, 10, 0);
    tick();
    set_op(0, 0, 0, 0, 0);
    tick();
    tick();
    n_checks++;
    if ({cdb_valid, cdb_roben, cdb_result} !== {1'b1, 5'd8, 32'd99}) begin
      n_errors++; $display("FAIL store_readback: got v=%b t=%0d r=%0d want 1 8 99", cdb_valid, cdb_roben, cdb_result);
    end
  endtask

  task automatic test_full();
    set_op(1, 1, 1, 20, 7);
    tick();
    for (int k = 2; k <= 4; k++) begin
      set_op(1, 0, 5'(k), 32'(19 + k), 0);
      tick();
    end
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready: got %b want 0", in_ready); end
    set_op(1, 0, 5, 24, 0);
    tick();
    set_op(0, 0, 0, 0, 0);
    n_checks++;
    if ({in_ready, mem_read_en, mem_write_en} !== 3'b000) begin
      n_errors++; $display("FAIL full_drop: got rdy=%b rd=%b wr=%b want 0 0 0", in_ready, mem_read_en, mem_write_en);
    end
    commit_valid = 1'b1; commit_roben = 5'd1;
    tick();
    commit_valid = 1'b0;
    n_checks++;
    if ({mem_write_en, mem_roben, in_ready} !== {1'b1, 5'd1, 1'b1}) begin
      n_errors++; $display("FAIL full_commit: got wr=%b t=%0d rdy=%b want 1 1 1", mem_write_en, mem_roben, in_ready);
    end
    for (int j = 0; j < 5; j++) begin
      logic exp_rd, exp_cdb;
      tick();
      exp_rd  = (j < 3);
      exp_cdb = (j >= 1 && j <= 3);
      n_checks++;
      if (mem_read_en !== exp_rd || (exp_rd && mem_roben !== 5'(2 + j))) begin
        n_errors++; $display("FAIL full_drain_rd[%0d]: got rd=%b t=%0d want rd=%b t=%0d", j, mem_read_en, mem_roben, exp_rd, 2 + j);
      end
      n_checks++;
      if (cdb_valid !== exp_cdb || (exp_cdb && {cdb_roben, cdb_result} !== {5'(1 + j), init_word(6'(20 + j))})) begin
        n_errors++; $display("FAIL full_drain_cdb[%0d]: got v=%b t=%0d r=%0d want v=%b t=%0d r=%0d",
                             j, cdb_valid, cdb_roben, cdb_result, exp_cdb, 1 + j, init_word(6'(20 + j)));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 6; j++) begin
      logic exp_rd, exp_cdb;
      if (j < 4) set_op(1, 0, 5'(11 + j), 32'(30 + j), 0);
      else       set_op(0, 0, 0, 0, 0);
      tick();
      exp_rd  = (j >= 1 && j <= 4);
      exp_cdb = (j >= 2);
      n_checks++;
      if (in_ready !== 1'b1 || mem_read_en !== exp_rd || (exp_rd && mem_roben !== 5'(10 + j))) begin
        n_errors++; $display("FAIL b2b_rd[%0d]: got rdy=%b rd=%b t=%0d want 1 %b %0d", j, in_ready, mem_read_en, mem_roben, exp_rd, 10 + j);
      end
      n_checks++;
      if (cdb_valid !== exp_cdb || (exp_cdb && {cdb_roben, cdb_result} !== {5'(9 + j), init_word(6'(28 + j))})) begin
        n_errors++; $display("FAIL b2b_cdb[%0d]: got v=%b t=%0d r=%0d want %b %0d %0d",
                             j, cdb_valid, cdb_roben, cdb_result, exp_cdb, 9 + j, init_word(6'(28 + j)));
      end
    end
  endtask

  task automatic test_flush();
    logic seen;
    set_op(1, 1, 15, 50, 5); tick();
    set_op(1, 0, 16, 51, 0); tick();
    set_op(1, 0, 17, 52, 0); tick();
    set_op(1, 0, 18, 53, 0); tick();
    set_op(0, 0, 0, 0, 0);
    commit_valid = 1'b1; commit_roben = 5'd15;
    tick();
    commit_valid = 1'b0;
    set_op(1, 0, 19, 54, 0);
    tick();
    n_checks++;
    if ({mem_read_en, mem_roben, in_ready} !== {1'b1, 5'd16, 1'b1}) begin
      n_errors++; $display("FAIL flush_pre: got rd=%b t=%0d rdy=%b want 1 16 1", mem_read_en, mem_roben, in_ready);
    end
    flush = 1'b1;
    set_op(1, 0, 25, 55, 0);
    tick();
    flush = 1'b0;
    set_op(0, 0, 0, 0, 0);
    n_checks++;
    if ({cdb_valid, mem_read_en, mem_write_en, in_ready} !== 4'b0001) begin
      n_errors++; $display("FAIL flush_edge: got v=%b rd=%b wr=%b rdy=%b want 0 0 0 1", cdb_valid, mem_read_en, mem_write_en, in_ready);
    end
    seen = 1'b0;
    repeat (3) begin
      tick();
      seen = seen | cdb_valid | mem_read_en | mem_write_en;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_errors++; $display("FAIL flush_quiet: got activity=%b want 0", seen); end
    set_op(1, 1, 26, 56, 0); tick();
    set_op(1, 0, 27, 57, 0); tick();
    set_op(1, 0, 28, 58, 0); tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL flush_count3: got rdy=%b want 1", in_ready); end
    set_op(1, 0, 29, 59, 0); tick();
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_count4: got rdy=%b want 0", in_ready); end
    set_op(0, 0, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
  endtask

  task automatic test_tag_err();
    force_en = 1'b1; force_tag = 5'd9;
    set_op(1, 0, 2, 2, 0);
    tick();
    set_op(0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if ({mem_read_en, tag_err} !== 2'b10) begin
      n_errors++; $display("FAIL tag_pre: got rd=%b err=%b want 1 0", mem_read_en, tag_err);
    end
    tick();
    force_en = 1'b0;
    n_checks++;
    if ({cdb_valid, cdb_roben, cdb_result, tag_err} !== {1'b1, 5'd2, 32'd18, 1'b1}) begin
      n_errors++; $display("FAIL tag_set: got v=%b t=%0d r=%0d err=%b want 1 2 18 1", cdb_valid, cdb_roben, cdb_result, tag_err);
    end
    set_op(1, 0, 4, 7, 0);
    tick();
    set_op(0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    n_checks++;
    if (tag_err !== 1'b1) begin n_errors++; $display("FAIL tag_sticky: got err=%b want 1", tag_err); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    set_op(1, 0, 22, 4, 0);
    tick();
    set_op(1, 1, 23, 60, 1);
    tick();
    set_op(0, 0, 0, 0, 0);
    n_checks++;
    if ({mem_read_en, mem_roben} !== {1'b1, 5'd22}) begin
      n_errors++; $display("FAIL rmid_pre: got rd=%b t=%0d want 1 22", mem_read_en, mem_roben);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, mem_read_en, mem_write_en, mem_addr, mem_data, mem_roben} !== {1'b1, 71'd0}) begin
      n_errors++; $display("FAIL rmid_mem: got rdy=%b rd=%b wr=%b a=%0h d=%0h t=%0d want 1 and all 0",
                           in_ready, mem_read_en, mem_write_en, mem_addr, mem_data, mem_roben);
    end
    n_checks++;
    if ({cdb_valid, cdb_roben, cdb_result, tag_err} !== 39'd0) begin
      n_errors++; $display("FAIL rmid_cdb: got v=%b t=%0d r=%0h err=%b want all 0", cdb_valid, cdb_roben, cdb_result, tag_err);
    end
    tick();
    tick();
    rst = 1'b1;
    commit_valid = 1'b1; commit_roben = 5'd23;
    seen = 1'b0;
    repeat (3) begin
      tick();
      seen = seen | cdb_valid | mem_read_en | mem_write_en;
    end
    commit_valid = 1'b0;
    n_checks++;
    if (seen !== 1'b0) begin n_errors++; $display("FAIL rmid_abandon: got activity=%b want 0", seen); end
    set_op(1, 0, 24, 6, 0);
    tick();
    set_op(0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if ({mem_read_en, mem_addr, mem_roben} !== {1'b1, 32'd6, 5'd24}) begin
      n_errors++; $display("FAIL rmid_resume_rd: got rd=%b a=%0d t=%0d want 1 6 24", mem_read_en, mem_addr, mem_roben);
    end
    tick();
    n_checks++;
    if ({cdb_valid, cdb_roben, cdb_result, tag_err} !== {1'b1, 5'd24, 32'd50, 1'b0}) begin
      n_errors++; $display("FAIL rmid_resume_cdb: got v=%b t=%0d r=%0d err=%b want 1 24 50 0",
                           cdb_valid, cdb_roben, cdb_result, tag_err);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_full();
    test_back_to_back();
    test_flush();
    test_tag_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
